// File: rtl/toggle_event_gen_pkg.sv
// ----------------------------------------------------------------------------
// toggle_event_gen_pkg
// Shared definitions for the toggle event generator:
//   - DIR_RISE / DIR_FALL : direction offsets inside a bit's cover-point pair
//   - toggle_idx()        : maps (signal bit, direction) to a cover-point index
//   - tog_state_e         : sampler state (WARM = no valid previous sample)
// ----------------------------------------------------------------------------
package toggle_event_gen_pkg;

    localparam int unsigned DIR_RISE = 0;
    localparam int unsigned DIR_FALL = 1;

    typedef enum logic {
        ST_WARM  = 1'b0,
        ST_ARMED = 1'b1
    } tog_state_e;

    // Each monitored bit owns two adjacent cover points: rise, then fall.
    function automatic int unsigned toggle_idx(input int unsigned bit_i,
                                               input int unsigned dir_i);
        return 2 * bit_i + dir_i;
    endfunction

endpackage

// File: rtl/toggle_event_gen_if.sv
// ----------------------------------------------------------------------------
// toggle_event_gen_if
// Bundles the sampling controls and the coverage outputs of toggle_event_gen.
//   en       : sampling enable            (master -> slave)
//   clear    : one-cycle mask clear       (master -> slave)
//   sig      : monitored signal, WIDTH    (master -> slave)
//   valid    : rise/fall event pulses     (slave -> master)
//   hit_mask : sticky points-hit bitmap   (slave -> master)
//   hit_cnt  : popcount of hit_mask       (slave -> master)
//   all_hit  : every point has been hit   (slave -> master)
// ----------------------------------------------------------------------------
interface toggle_event_gen_if #(
    parameter int WIDTH = 1
);
    import toggle_event_gen_pkg::*;

    localparam int CNT_W = $clog2(2 * WIDTH + 1);

    logic                 en;
    logic                 clear;
    logic [WIDTH-1:0]     sig;
    logic [2*WIDTH-1:0]   valid;
    logic [2*WIDTH-1:0]   hit_mask;
    logic [CNT_W-1:0]     hit_cnt;
    logic                 all_hit;

    modport master (
        output en, clear, sig,
        input  valid, hit_mask, hit_cnt, all_hit
    );

    modport slave (
        input  en, clear, sig,
        output valid, hit_mask, hit_cnt, all_hit
    );

endinterface

// File: rtl/toggle_event_gen_popcount.sv
// ----------------------------------------------------------------------------
// toggle_event_gen_popcount
// Combinational population count.
//   in_i  : N-bit vector
//   cnt_o : number of ones in in_i, $clog2(N+1) bits (holds N exactly)
// ----------------------------------------------------------------------------
module toggle_event_gen_popcount #(
    parameter int N = 2
) (
    input  logic [N-1:0]             in_i,
    output logic [$clog2(N+1)-1:0]   cnt_o
);
    localparam int OUT_W = $clog2(N + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + OUT_W'(in_i[i]);
        end
    end

endmodule

// File: rtl/toggle_event_gen.sv
// ----------------------------------------------------------------------------
// toggle_event_gen
// Samples a WIDTH-bit signal and emits registered one-cycle rise/fall pulses
// for 2*WIDTH toggle cover points, plus a sticky hit mask, its popcount and an
// all-hit flag. With ONCE=1 each point fires at most once until cleared.
//   clock : single clock, posedge
//   reset : synchronous, active-high
//   bus   : toggle_event_gen_if.slave (en, clear, sig in; valid, hit_mask,
//           hit_cnt, all_hit out)
// ----------------------------------------------------------------------------
module toggle_event_gen
    import toggle_event_gen_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter bit ONCE  = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    toggle_event_gen_if.slave  bus
);
    localparam int PTS   = 2 * WIDTH;
    localparam int CNT_W = $clog2(PTS + 1);

    tog_state_e          state_q, state_d;
    logic [WIDTH-1:0]    prev_q,  prev_d;
    logic [PTS-1:0]      valid_q, valid_d;
    logic [PTS-1:0]      mask_q,  mask_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                all_q,   all_d;

    logic                sample_ok;
    logic [PTS-1:0]      raw;

    // Edges are only meaningful once a previous sample exists and en is high.
    assign sample_ok = (state_q == ST_ARMED) && bus.en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_edge
        assign raw[toggle_idx(i, DIR_RISE)] = sample_ok &  bus.sig[i] & ~prev_q[i];
        assign raw[toggle_idx(i, DIR_FALL)] = sample_ok & ~bus.sig[i] &  prev_q[i];
    end

    always_comb begin
        state_d = bus.en ? ST_ARMED : ST_WARM;
        prev_d  = bus.en ? bus.sig : prev_q;
        // ONCE filtering uses the mask as it stood before this cycle's hits,
        // even when clear is asserted in the same cycle.
        valid_d = ONCE ? (raw & ~mask_q) : raw;
        // Clear wins over the old mask but keeps hits landing in this cycle.
        mask_d  = bus.clear ? raw : (mask_q | raw);
        all_d   = &mask_d;
    end

    // Count from the next-state mask so hit_cnt tracks hit_mask cycle for cycle.
    toggle_event_gen_popcount #(
        .N (PTS)
    ) u_popcount (
        .in_i  (mask_d),
        .cnt_o (cnt_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_WARM;
            prev_q  <= '0;
            valid_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            all_q   <= all_d;
        end
    end

    assign bus.valid    = valid_q;
    assign bus.hit_mask = mask_q;
    assign bus.hit_cnt  = cnt_q;
    assign bus.all_hit  = all_q;

endmodule

// File: tb/tb_toggle_event_gen.sv
// ----------------------------------------------------------------------------
// tb_toggle_event_gen
// Drives one stimulus stream into a ONCE=0 and a ONCE=1 instance (WIDTH=4)
// and checks both against a point-by-point behavioural model every cycle,
// plus literal expectations at the directed scenarios.
// ----------------------------------------------------------------------------
module tb_toggle_event_gen;

    localparam int W = 4;
    localparam int P = 2 * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clr;
    logic [W-1:0] sig;
    bit           run = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    toggle_event_gen_if #(.WIDTH(W)) bus0 ();
    toggle_event_gen_if #(.WIDTH(W)) bus1 ();

    assign bus0.en = en;  assign bus0.clear = clr;  assign bus0.sig = sig;
    assign bus1.en = en;  assign bus1.clear = clr;  assign bus1.sig = sig;

    toggle_event_gen #(.WIDTH(W), .ONCE(1'b0)) dut_n (
        .clock (clk),
        .reset (rst),
        .bus   (bus0)
    );

    toggle_event_gen #(.WIDTH(W), .ONCE(1'b1)) dut_o (
        .clock (clk),
        .reset (rst),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 = ONCE=0, index 1 = ONCE=1.
    logic [P-1:0] m_valid [2];
    logic [P-1:0] m_mask  [2];
    int           m_cnt   [2];
    bit           m_have;
    logic [W-1:0] m_prev;

    always @(posedge clk) begin
        logic [P-1:0] ev;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = '0;
                m_mask[k]  = '0;
                m_cnt[k]   = 0;
            end
            m_have = 1'b0;
            m_prev = '0;
        end else begin
            ev = '0;
            for (int p = 0; p < P; p++) begin
                int  b;
                bit  want_high;
                b         = p / 2;
                want_high = (p % 2 == 0);
                if (en && m_have && (sig[b] != m_prev[b]) && (sig[b] == want_high))
                    ev[p] = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = (k == 1) ? (ev & ~m_mask[k]) : ev;
                m_mask[k]  = clr ? ev : (m_mask[k] | ev);
                m_cnt[k]   = 0;
                for (int p = 0; p < P; p++) if (m_mask[k][p]) m_cnt[k]++;
            end
            if (en) begin
                m_prev = sig;
                m_have = 1'b1;
            end else begin
                m_have = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run) begin
            chk("n.valid",    32'(bus0.valid),    32'(m_valid[0]));
            chk("n.hit_mask", 32'(bus0.hit_mask), 32'(m_mask[0]));
            chk("n.hit_cnt",  32'(bus0.hit_cnt),  32'(m_cnt[0]));
            chk("n.all_hit",  32'(bus0.all_hit),  32'(m_cnt[0] == P));
            chk("o.valid",    32'(bus1.valid),    32'(m_valid[1]));
            chk("o.hit_mask", 32'(bus1.hit_mask), 32'(m_mask[1]));
            chk("o.hit_cnt",  32'(bus1.hit_cnt),  32'(m_cnt[1]));
            chk("o.all_hit",  32'(bus1.all_hit),  32'(m_cnt[1] == P));
        end
    end

    // Apply inputs at a negedge and return at the next negedge, after the
    // intervening posedge has registered the result.
    task automatic drive(input bit r, input bit e, input bit c, input logic [W-1:0] s);
        rst = r; en = e; clr = c; sig = s;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; sig = '0;
        @(negedge clk);
        drive(1, 0, 0, 4'h0);
        drive(1, 0, 0, 4'h0);
        run = 1'b1;
        chk("reset valid",   32'(bus0.valid),    32'h0);
        chk("reset cnt",     32'(bus0.hit_cnt),  32'h0);
        chk("reset o.mask",  32'(bus1.hit_mask), 32'h0);
        chk("reset all_hit", 32'(bus0.all_hit),  32'h0);

        // Warm-up sample with all ones: no events.
        drive(0, 1, 0, 4'hF);
        chk("warm valid", 32'(bus0.valid),   32'h0);
        chk("warm cnt",   32'(bus0.hit_cnt), 32'h0);

        // Single rise, then multi-bit rise/fall.
        drive(1, 0, 0, 4'h0);
        drive(0, 1, 0, 4'h0);
        drive(0, 1, 0, 4'h1);
        chk("rise valid", 32'(bus0.valid),    32'h01);
        chk("rise mask",  32'(bus0.hit_mask), 32'h01);
        chk("rise cnt",   32'(bus0.hit_cnt),  32'h1);
        drive(0, 1, 0, 4'h1);
        chk("rise one-cycle", 32'(bus0.valid), 32'h0);
        drive(0, 1, 0, 4'h6);
        chk("multi valid",   32'(bus0.valid),   32'h16);
        chk("multi cnt",     32'(bus0.hit_cnt), 32'h4);
        chk("multi o.valid", 32'(bus1.valid),   32'h16);

        // ONCE repeat suppression on sig[0].
        drive(1, 0, 0, 4'h0);
        drive(0, 1, 0, 4'h0);
        drive(0, 1, 0, 4'h1);
        chk("once rise1",  32'(bus1.valid), 32'h01);
        drive(0, 1, 0, 4'h0);
        chk("once fall1",  32'(bus1.valid), 32'h02);
        drive(0, 1, 0, 4'h1);
        chk("once rise2",  32'(bus1.valid), 32'h00);
        chk("norm rise2",  32'(bus0.valid), 32'h01);

        // Full coverage, then clear with a same-cycle sig[2] rise.
        drive(1, 0, 0, 4'h0);
        drive(0, 1, 0, 4'h0);
        drive(0, 1, 0, 4'hF);
        chk("full rises", 32'(bus0.valid), 32'h55);
        drive(0, 1, 0, 4'h0);
        chk("full falls", 32'(bus0.valid),   32'hAA);
        chk("full cnt",   32'(bus0.hit_cnt), 32'h8);
        chk("full all",   32'(bus0.all_hit), 32'h1);
        drive(0, 1, 1, 4'h4);
        chk("clr mask",    32'(bus0.hit_mask), 32'h10);
        chk("clr cnt",     32'(bus0.hit_cnt),  32'h1);
        chk("clr all",     32'(bus0.all_hit),  32'h0);
        chk("clr n.valid", 32'(bus0.valid),    32'h10);
        chk("clr o.valid", 32'(bus1.valid),    32'h00);
        chk("clr o.mask",  32'(bus1.hit_mask), 32'h10);
        drive(0, 1, 0, 4'h0);
        chk("post-clr o.valid", 32'(bus1.valid), 32'h20);

        // Enable gap: change while disabled produces no false edge.
        drive(0, 0, 0, 4'h0);
        drive(0, 0, 0, 4'hF);
        drive(0, 1, 0, 4'hF);
        chk("gap n.valid", 32'(bus0.valid), 32'h0);
        chk("gap o.valid", 32'(bus1.valid), 32'h0);
        drive(0, 1, 0, 4'hE);
        chk("gap real edge", 32'(bus0.valid), 32'h02);
        chk("gap o edge",    32'(bus1.valid), 32'h02);

        // Clear while disabled.
        drive(0, 0, 1, 4'h5);
        chk("clr !en mask",  32'(bus0.hit_mask), 32'h0);
        chk("clr !en valid", 32'(bus0.valid),    32'h0);
        chk("clr !en cnt",   32'(bus0.hit_cnt),  32'h0);

        // Reset in the middle of a burst.
        drive(0, 1, 0, 4'h5);
        drive(0, 1, 0, 4'hA);
        chk("burst valid", 32'(bus0.valid), 32'h66);
        drive(1, 1, 0, 4'h5);
        chk("mid-rst valid", 32'(bus0.valid),    32'h0);
        chk("mid-rst mask",  32'(bus0.hit_mask), 32'h0);
        chk("mid-rst cnt",   32'(bus1.hit_cnt),  32'h0);
        chk("mid-rst all",   32'(bus0.all_hit),  32'h0);
        drive(0, 1, 0, 4'hA);
        chk("post-rst warm", 32'(bus0.valid), 32'h0);

        // Pseudo-random traffic checked by the per-cycle model comparison.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 15) == 0),
                  W'($urandom));
        end

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
